// File: rtl/lru_writeback_queue_if.sv
// Eviction push side and DDR2 issue side of the LRU writeback queue.
// The cache/traffic stage takes master; the queue takes slave.
interface lru_writeback_queue_if;
    logic        wr_valid;
    logic [63:0] wr_data;
    logic        wr_ready;
    logic        mem_done;
    logic [63:0] send_mem;
    logic        mem_flag;

    modport master (
        output wr_valid, wr_data, mem_done,
        input  wr_ready, send_mem, mem_flag
    );

    modport slave (
        input  wr_valid, wr_data, mem_done,
        output wr_ready, send_mem, mem_flag
    );
endinterface

// File: rtl/lru_writeback_queue.sv
// Buffers LRU evictions and issues them one at a time to the DDR2 stage, with an idle gap and a completion timeout.
// Latency: push-to-issue is 1 cycle when idle; backpressure: wr_ready drops at full and ignores same-cycle pops.
module lru_writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                       clk_cpu,
    input  logic                       rst,
    lru_writeback_queue_if.slave       bus,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       busy,
    output logic                       timeout_err
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [63:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [WAIT_W-1:0] wait_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [63:0]       send_mem_q;
    logic              mem_flag_q;

    logic push;
    logic pop;
    logic tmo_hit;
    logic wait_exit;

    assign bus.wr_ready = (level != LVL_W'(DEPTH));
    assign bus.send_mem = send_mem_q;
    assign bus.mem_flag = mem_flag_q;
    assign push         = bus.wr_valid & bus.wr_ready;

    // State register together with the counters and registered issue outputs.
    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            send_mem_q  <= '0;
            mem_flag_q  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_flag_q  <= pop;
            timeout_err <= timeout_err | tmo_hit;

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                send_mem_q <= mem[rd_ptr];
            end

            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            if (pop)
                wait_cnt <= '0;
            else if (state == WAIT && !wait_exit)
                wait_cnt <= wait_cnt + WAIT_W'(1);

            if (wait_exit)
                gap_cnt <= GAP_W'(GAP_CYCLES);
            else if (state == GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    // Storage has no reset; occupancy is tracked solely by level and the pointers.
    always_ff @(posedge clk_cpu) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (level != '0) state_nxt = WAIT;
            WAIT:    if (wait_exit) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt == GAP_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        pop       = (state == IDLE) && (level != '0);
        tmo_hit   = (state == WAIT) && !bus.mem_done && (wait_cnt == WAIT_W'(TIMEOUT - 1));
        wait_exit = (state == WAIT) && (bus.mem_done || tmo_hit);
    end
endmodule

// File: doc/lru_writeback_queue.md
# lru_writeback_queue

Buffers 64-bit words evicted by the LRU cache and delivers them one at a time to the DDR2 memory test/traffic stage through its `send_mem`/`mem_flag` word-plus-strobe interface. The block sits directly upstream of the memory traffic generator. It decouples bursty evictions from the slow DDR2 write/read cycle by holding each issued word until the memory side reports completion. It also enforces a programmable idle gap between consecutive transactions and flags transactions that never complete.

## Interface
- `DEPTH`, 4, number of FIFO entries; power of two, ≥2.
- `GAP_CYCLES`, 8, minimum idle cycles after a completed or timed-out transaction before the next issue; 0 allowed.
- `TIMEOUT`, 1024, maximum cycles to wait for `mem_done` after issue; ≥2.
- `clk_cpu` in 1: sole clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_valid` in 1: an eviction word is offered.
- `wr_data` in 64: the eviction word.
- `wr_ready` out 1: `level != DEPTH`; a push occurs when `wr_valid & wr_ready`.
- `mem_done` in 1: the memory side's transaction-complete pulse.
- `send_mem` out 64: the word being issued; registered, and held stable until the next issue.
- `mem_flag` out 1: one-cycle issue strobe.
- `level` out clog2(DEPTH+1): current FIFO occupancy.
- `busy` out 1: high while the state is not IDLE.
- `timeout_err` out 1: sticky; set on timeout and cleared only by `rst`.

## Operation
- The FIFO is circular, with `wr_ptr` and `rd_ptr` each clog2(DEPTH) bits wide. Both pointers wrap modulo DEPTH.
- `level` changes as follows:
  - Push only: increments.
  - Pop only: decrements.
  - Push and pop in the same cycle: unchanged.
- `wr_ready` is computed combinationally from `level` and does not anticipate a same-cycle pop. When the FIFO is full and a pop happens, the push is still refused in that cycle.
- A push while full is ignored: no state change and no error.
- The FSM has three states: IDLE, WAIT and GAP.
  - **IDLE**: if `level != 0`:
    - pop the head entry into `send_mem`;
    - assert `mem_flag` for the next cycle;
    - clear the wait counter;
    - go to WAIT.
  - **WAIT**: `mem_flag` is forced to 0 after its first cycle. The wait counter increments every cycle.
    - `mem_done` high (including the cycle in which `mem_flag` is high): go to GAP with the gap counter set to GAP_CYCLES, or go to IDLE if GAP_CYCLES = 0.
    - Otherwise, when the wait counter reaches TIMEOUT-1: set `timeout_err` and take the same exit as `mem_done`. The word is dropped, not retried.
  - **GAP**: the gap counter decrements each cycle. When it reaches 1, go to IDLE.
- `mem_done` received in IDLE or GAP is ignored.
- The pop happens on the IDLE→WAIT transition edge. A push in that same cycle obeys the level rule above.
- Reset mid-operation:
  - pointers, `level`, both counters and `timeout_err` are cleared;
  - the state returns to IDLE;
  - any buffered and in-flight words are discarded;
  - `send_mem` = 0 and `mem_flag` = 0 on the cycle after `rst` is sampled high.
- Reset values: `wr_ready`=1, `mem_flag`=0, `send_mem`=64'h0, `level`=0, `busy`=0, `timeout_err`=0.

## Timing
- Word accepted at edge N into an empty FIFO with the FSM in IDLE:
  - `level`=1 after N;
  - `mem_flag`=1 and `send_mem` valid after edge N+1;
  - `mem_flag`=0 after N+2.
- Issue-to-issue spacing with `mem_done` arriving k cycles after `mem_flag` rises (k=0 means the same cycle): next `mem_flag` rise is k+GAP_CYCLES+2 edges later (k+2 when GAP_CYCLES = 0).
- Timeout: with no `mem_done`, `timeout_err` rises TIMEOUT edges after the `mem_flag` rise.
- `send_mem` changes only on an issue edge.
- `mem_flag` is never high for two consecutive cycles.
- Wait and gap counters are each wide enough for their own parameter and never wrap.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `wr_valid`=1 → all outputs at their reset values and `level`=0 throughout; after release, the first push sets `level`=1.
- **Single word:** push 64'h0123456789ABCDEF at edge N; pulse `mem_done` 5 cycles after `mem_flag` → `send_mem` = 64'h0123456789ABCDEF after N+1; one-cycle `mem_flag`; `busy` returns to 0 GAP_CYCLES+1 edges after `mem_done`.
- **Fill and drain:** push 5 words 64'h1…64'h5 back-to-back with no `mem_done` → `wr_ready`=0 once `level`=4 (after the first pop, the 5th word is accepted); issue order is 1,2,3,4,5 with `mem_done` pulsed for each.
- **Full with simultaneous push/pop:** FIFO full (4), FSM in IDLE, `wr_valid`=1 → that edge pops, refuses the push, `level`=3; next edge pushes, `level`=4.
- **Timeout:** TIMEOUT=16, issue a word and never pulse `mem_done` → `timeout_err`=1 16 edges after the `mem_flag` rise; the next queued word still issues after the gap; `timeout_err` stays 1 until `rst`.
- **Spurious done and mid-flight reset:** pulse `mem_done` in IDLE → no effect; assert `rst` while in WAIT with `level`=2 → next cycle `level`=0, `busy`=0, `send_mem`=0, and no `mem_flag` until a new push.
